// File: rtl/io_filter_pkg.sv
// Shared constants and types for the GPIO input filter.
package io_filter_pkg;
    localparam int FILTER_BITS_DEFAULT = 6;
    localparam int SYNC_STAGES         = 2;

    typedef logic [FILTER_BITS_DEFAULT-1:0] filt_cnt_t;
endpackage

// File: rtl/io_filter_bit.sv
// One GPIO input bit: synchroniser, debounce counter, level, edge pulses and sticky flag.
module io_filter_bit
    import io_filter_pkg::*;
#(
    parameter int FilterBits = FILTER_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pin,
    input  logic [FilterBits-1:0] thresh,
    input  logic                  clr,
    output logic                  filtered,
    output logic                  rise,
    output logic                  fall,
    output logic                  sticky
);

    logic [SYNC_STAGES-1:0] sync;
    logic [FilterBits-1:0]  cnt;
    logic                   s2;
    logic                   accept;
    logic                   rise_next;
    logic                   fall_next;

    assign s2        = sync[SYNC_STAGES-1];
    // cnt >= thresh (not ==) so a threshold lowered mid-count accepts at once
    assign accept    = (s2 != filtered) && (cnt >= thresh);
    assign rise_next = accept & s2;
    assign fall_next = accept & ~s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync     <= '0;
            cnt      <= '0;
            filtered <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            sticky   <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            if (s2 == filtered) begin
                cnt <= '0;
            end else if (accept) begin
                filtered <= s2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + FilterBits'(1);
            end
            rise   <= rise_next;
            fall   <= fall_next;
            // a new edge in the clear cycle wins over the clear
            sticky <= (sticky & ~clr) | rise_next | fall_next;
        end
    end

endmodule

// File: rtl/io_input_filter.sv
// GPIO bank input conditioner: per-pin threshold select and sticky-clear gating over io_filter_bit.
module io_input_filter
    import io_filter_pkg::*;
#(
    parameter int IOWidth    = 36,
    parameter int FilterBits = FILTER_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [IOWidth-1:0]    pin_in,
    input  logic [IOWidth-1:0]    sel_fast,
    input  logic [FilterBits-1:0] filt_fast,
    input  logic [FilterBits-1:0] filt_slow,
    input  logic                  sticky_clr,
    input  logic [IOWidth-1:0]    sticky_clr_mask,
    output logic [IOWidth-1:0]    filtered,
    output logic [IOWidth-1:0]    rise,
    output logic [IOWidth-1:0]    fall,
    output logic [IOWidth-1:0]    sticky
);

    logic [IOWidth-1:0] clr_bits;

    assign clr_bits = sticky_clr ? sticky_clr_mask : '0;

    for (genvar i = 0; i < IOWidth; i++) begin : g_bit
        logic [FilterBits-1:0] thresh;

        assign thresh = sel_fast[i] ? filt_fast : filt_slow;

        io_filter_bit #(
            .FilterBits (FilterBits)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .pin      (pin_in[i]),
            .thresh   (thresh),
            .clr      (clr_bits[i]),
            .filtered (filtered[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .sticky   (sticky[i])
        );
    end

endmodule

// File: tb/tb_io_input_filter.sv
// Directed bench for io_input_filter: debounce latency, glitch rejection, edges, sticky, live threshold, reset.
module tb_io_input_filter;
    import io_filter_pkg::*;

    localparam int IOWidth    = 36;
    localparam int FilterBits = FILTER_BITS_DEFAULT;
    localparam logic [IOWidth-1:0] PAT_A = 36'hA_AAAA_AAAA;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [IOWidth-1:0]    pin_in = '0;
    logic [IOWidth-1:0]    sel_fast = '0;
    filt_cnt_t             filt_fast = '0;
    filt_cnt_t             filt_slow = '0;
    logic                  sticky_clr = 1'b0;
    logic [IOWidth-1:0]    sticky_clr_mask = '0;
    logic [IOWidth-1:0]    filtered, rise, fall, sticky;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    io_input_filter #(
        .IOWidth    (IOWidth),
        .FilterBits (FilterBits)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pin_in          (pin_in),
        .sel_fast        (sel_fast),
        .filt_fast       (filt_fast),
        .filt_slow       (filt_slow),
        .sticky_clr      (sticky_clr),
        .sticky_clr_mask (sticky_clr_mask),
        .filtered        (filtered),
        .rise            (rise),
        .fall            (fall),
        .sticky          (sticky)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [IOWidth-1:0] prev, val;

        // reset state
        #12;
        chk("rst_filtered", filtered, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_rise_fall", rise | fall, 0);
        filt_slow = 6'd4;
        filt_fast = 6'd3;
        @(posedge clk); #3 reset_n = 1'b1;
        step(2);

        // T_s=4 on bit 0: accept after edge 6, fall 7 edges after release
        pin_in = 36'h1;
        step(6);
        chk("t1_before", filtered, 0);
        step(1);
        chk("t1_filtered", filtered, 36'h1);
        chk("t1_rise", rise, 36'h1);
        chk("t1_sticky", sticky, 36'h1);
        step(1);
        chk("t1_rise_once", rise, 0);
        step(2);
        pin_in = '0;
        step(6);
        chk("t1_hold", filtered, 36'h1);
        chk("t1_nofall", fall, 0);
        step(1);
        chk("t1_fall", fall, 36'h1);
        chk("t1_low", filtered, 0);
        sticky_clr = 1'b1; sticky_clr_mask = 36'h1;
        step(1);
        sticky_clr = 1'b0;
        chk("t1_clr", sticky, 0);

        // glitch rejection on bit 5 with T_f=3
        sel_fast = 36'h20;
        pin_in = 36'h20;
        step(3);
        pin_in = '0;
        step(8);
        chk("t2_glitch_filt", filtered, 0);
        chk("t2_glitch_sticky", sticky, 0);
        pin_in = 36'h20;
        step(4);
        pin_in = '0;
        step(1);
        chk("t2_pre_accept", filtered, 0);
        step(1);
        chk("t2_accept", filtered, 36'h20);
        chk("t2_rise", rise, 36'h20);
        step(3);
        chk("t2_pre_fall", fall, 0);
        step(1);
        chk("t2_fall", fall, 36'h20);
        chk("t2_low", filtered, 0);

        // T=0 on all bits, toggling pattern
        sel_fast = '1;
        filt_fast = '0;
        prev = '0;
        for (int i = 0; i < 4; i++) begin
            val = (i % 2 == 0) ? PAT_A : '0;
            pin_in = val;
            step(2);
            chk("t3_lag", filtered, prev);
            step(1);
            chk("t3_follow", filtered, val);
            chk("t3_rise", rise, (i % 2 == 0) ? PAT_A : 36'h0);
            chk("t3_fall", fall, (i % 2 == 0) ? 36'h0 : PAT_A);
            step(1);
            chk("t3_pulse_end", rise | fall, 0);
            prev = val;
        end
        chk("t3_sticky", sticky, PAT_A);

        // sticky clear: set wins, unmasked bits untouched
        sticky_clr = 1'b1; sticky_clr_mask = '1;
        step(1);
        sticky_clr = 1'b0;
        chk("t4_clr_all", sticky, 0);
        pin_in = 36'h6;
        step(3);
        chk("t4_set", sticky, 36'h6);
        pin_in = 36'h4;
        step(3);
        chk("t4_fall1", fall, 36'h2);
        pin_in = 36'h6;
        step(2);
        sticky_clr = 1'b1; sticky_clr_mask = 36'h2;
        step(1);
        chk("t4_rise1", rise, 36'h2);
        chk("t4_set_wins", sticky, 36'h6);
        step(1);
        sticky_clr = 1'b0;
        chk("t4_clr1", sticky, 36'h4);

        // live threshold drop
        sel_fast = '0;
        filt_slow = 6'd40;
        pin_in = 36'hE;
        step(20);
        chk("t5_counting", filtered, 36'h6);
        filt_slow = 6'd5;
        step(1);
        chk("t5_accept", filtered, 36'hE);
        chk("t5_rise", rise, 36'h8);
        step(1);
        chk("t5_rise_once", rise, 0);

        // async reset mid-count
        filt_slow = 6'd4;
        pin_in = 36'hF;
        step(4);
        reset_n = 1'b0;
        #2;
        chk("t6_rst_filt", filtered, 0);
        chk("t6_rst_sticky", sticky, 0);
        chk("t6_rst_edges", rise | fall, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        step(6);
        chk("t6_pre", filtered, 0);
        step(1);
        chk("t6_filtered", filtered, 36'hF);
        chk("t6_rise", rise, 36'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
